// File: rtl/hslp_acc_stage.sv
// Dot-product accumulator behind the HSLP 8x8 approximate multiplier.
// Sums VEC_LEN products and hands back the total and a sticky overflow flag over valid/ready.
module hslp_acc_stage #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 8,
    parameter bit SAT     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CW-1:0]    count;
    logic             ovf_acc, ovf_nxt;
    logic [ACC_W:0]   sum;
    logic             carry, accept, last, done;

    // Handshake signals derive from state alone so in_ready never depends on in_valid.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready && !clr;
    assign done      = out_valid && out_ready;
    assign last      = (count == LAST);

    assign sum     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry   = sum[ACC_W];
    assign acc_nxt = (SAT && carry) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    assign ovf_nxt = ovf_acc | carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, ACC: if (accept) state_nxt = last ? HOLD : ACC;
                HOLD:      if (out_ready) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            count   <= '0;
            ovf_acc <= 1'b0;
            acc_out <= '0;
            ovf     <= 1'b0;
        end else if (clr || done) begin
            // acc_out keeps its last value; ovf reads 0 outside HOLD.
            acc     <= '0;
            count   <= '0;
            ovf_acc <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            acc     <= acc_nxt;
            count   <= count + 1'b1;
            ovf_acc <= ovf_nxt;
            if (last) begin
                acc_out <= acc_nxt;
                ovf     <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_hslp_acc_stage.sv
// Bench for hslp_acc_stage: three instances (24-bit saturating, 17-bit saturating, 17-bit wrapping)
// share one stimulus stream; a negedge scoreboard tracks results alongside directed scenario tasks.
module tb_hslp_acc_stage;
    logic        clk, rst_n, clr, in_valid, out_ready;
    logic [15:0] prod;
    logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
    logic [23:0] acc0;
    logic [16:0] acc1, acc2;

    int n_cmp = 0;
    int n_err = 0;

    hslp_acc_stage #(.PROD_W(16), .ACC_W(24), .VEC_LEN(4), .SAT(1'b1)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir0), .prod(prod),
        .out_valid(ov0), .out_ready(out_ready), .acc_out(acc0), .ovf(of0));
    hslp_acc_stage #(.PROD_W(16), .ACC_W(17), .VEC_LEN(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir1), .prod(prod),
        .out_valid(ov1), .out_ready(out_ready), .acc_out(acc1), .ovf(of1));
    hslp_acc_stage #(.PROD_W(16), .ACC_W(17), .VEC_LEN(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir2), .prod(prod),
        .out_valid(ov2), .out_ready(out_ready), .acc_out(acc2), .ovf(of2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: {ovf, acc[24:0]} per instance
    logic [25:0] m_st[3];
    logic [25:0] q0[$], q1[$], q2[$];
    bit          m_hold;
    int          m_cnt;
    int          w_of[3]   = '{24, 17, 17};
    bit          sat_of[3] = '{1'b1, 1'b1, 1'b0};

    function automatic logic [25:0] mstep(input logic [25:0] st, input logic [15:0] p,
                                          input int w, input bit sat);
        logic [25:0] s;
        logic [24:0] mask, a;
        logic        c;
        mask = (25'd1 << w) - 25'd1;
        s    = {1'b0, st[24:0]} + {10'd0, p};
        c    = s[w];
        a    = (c && sat) ? mask : (s[24:0] & mask);
        return {st[25] | c, a};
    endfunction

    initial begin
        m_hold = 0;
        m_cnt  = 0;
        for (int i = 0; i < 3; i++) m_st[i] = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hold = 0;
                m_cnt  = 0;
                for (int i = 0; i < 3; i++) m_st[i] = '0;
                q0.delete(); q1.delete(); q2.delete();
            end else begin
                n_cmp++;
                if (ov0 !== m_hold || ir0 !== !m_hold || ov1 !== m_hold || ov2 !== m_hold) begin
                    n_err++;
                    $display("FAIL sb_handshake out_valid=%b/%b/%b in_ready=%b expected out_valid=%b",
                             ov0, ov1, ov2, ir0, m_hold);
                end
                if (m_hold) begin
                    n_cmp++;
                    if (q0.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_empty no expected result queued");
                    end else if ({of0, 1'b0, acc0} !== q0[0] || {of1, 8'd0, acc1} !== q1[0] ||
                                 {of2, 8'd0, acc2} !== q2[0]) begin
                        n_err++;
                        $display("FAIL sb_result got %h/%b %h/%b %h/%b want %h %h %h",
                                 acc0, of0, acc1, of1, acc2, of2, q0[0], q1[0], q2[0]);
                    end
                end
                if (clr) begin
                    m_hold = 0;
                    m_cnt  = 0;
                    for (int i = 0; i < 3; i++) m_st[i] = '0;
                    q0.delete(); q1.delete(); q2.delete();
                end else if (m_hold) begin
                    if (out_ready) begin
                        void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
                        m_hold = 0;
                    end
                end else if (in_valid) begin
                    for (int i = 0; i < 3; i++) m_st[i] = mstep(m_st[i], prod, w_of[i], sat_of[i]);
                    m_cnt++;
                    if (m_cnt == 4) begin
                        q0.push_back(m_st[0]); q1.push_back(m_st[1]); q2.push_back(m_st[2]);
                        m_hold = 1;
                        m_cnt  = 0;
                        for (int i = 0; i < 3; i++) m_st[i] = '0;
                    end
                end
            end
        end
    end

    task automatic beat(input logic v, input logic [15:0] p);
        in_valid = v;
        prod     = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (ov0 !== 1'b0 || acc0 !== 24'd0 || of0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state out_valid=%b acc_out=%0d ovf=%b want 0/0/0", ov0, acc0, of0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ir0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready in_ready=%b want 1", ir0);
        end
        beat(0, 0);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        beat(1, 100); beat(1, 200); beat(1, 300);
        n_cmp++;
        if (ov0 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early out_valid=%b want 0", ov0);
        end
        beat(1, 400);
        n_cmp++;
        if (ov0 !== 1'b1 || acc0 !== 24'd1000 || of0 !== 1'b0 || ir0 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result out_valid=%b acc_out=%0d ovf=%b in_ready=%b want 1/1000/0/0",
                     ov0, acc0, of0, ir0);
        end
        beat(0, 0);
        n_cmp++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_idle out_valid=%b in_ready=%b want 0/1", ov0, ir0);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        beat(1, 100); beat(1, 200); beat(1, 300); beat(1, 400);
        for (int i = 0; i < 5; i++) begin
            beat(1, 55);
            n_cmp++;
            if (ir0 !== 1'b0 || ov0 !== 1'b1 || acc0 !== 24'd1000) begin
                n_err++;
                $display("FAIL bp_hold[%0d] in_ready=%b out_valid=%b acc_out=%0d want 0/1/1000",
                         i, ir0, ov0, acc0);
            end
        end
        out_ready = 1'b1;
        beat(0, 0);
        beat(1, 1); beat(1, 2); beat(1, 3); beat(1, 4);
        n_cmp++;
        if (ov0 !== 1'b1 || acc0 !== 24'd10) begin
            n_err++;
            $display("FAIL bp_next out_valid=%b acc_out=%0d want 1/10", ov0, acc0);
        end
        beat(0, 0);
    endtask

    task automatic test_ovf;
        out_ready = 1'b1;
        repeat (4) beat(1, 16'hFFFF);
        n_cmp++;
        if (acc1 !== 17'h1FFFF || of1 !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sat acc_out=%h ovf=%b want 1ffff/1", acc1, of1);
        end
        n_cmp++;
        if (acc2 !== 17'h1FFFC || of2 !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_wrap acc_out=%h ovf=%b want 1fffc/1", acc2, of2);
        end
        n_cmp++;
        if (acc0 !== 24'h03FFFC || of0 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_wide acc_out=%h ovf=%b want 03fffc/0", acc0, of0);
        end
        beat(0, 0);
    endtask

    task automatic test_gaps;
        logic [6:0] pat;
        pat = 7'b1101001;  // issued LSB first: 1,0,0,1,0,1,1
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            beat(pat[k], 10);
            if (k < 6) begin
                n_cmp++;
                if (ov0 !== 1'b0) begin
                    n_err++;
                    $display("FAIL gaps_early[%0d] out_valid=%b want 0", k, ov0);
                end
            end
        end
        n_cmp++;
        if (ov0 !== 1'b1 || acc0 !== 24'd40) begin
            n_err++;
            $display("FAIL gaps_result out_valid=%b acc_out=%0d want 1/40", ov0, acc0);
        end
        beat(0, 0);
    endtask

    task automatic test_clr;
        out_ready = 1'b1;
        beat(1, 5); beat(1, 7);
        clr = 1'b1;
        beat(1, 9);
        clr = 1'b0;
        n_cmp++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            n_err++;
            $display("FAIL clr_idle out_valid=%b in_ready=%b want 0/1", ov0, ir0);
        end
        beat(1, 1); beat(1, 2); beat(1, 3); beat(1, 4);
        n_cmp++;
        if (ov0 !== 1'b1 || acc0 !== 24'd10 || of0 !== 1'b0) begin
            n_err++;
            $display("FAIL clr_result out_valid=%b acc_out=%0d ovf=%b want 1/10/0", ov0, acc0, of0);
        end
        beat(0, 0);
        // clr while a result is pending drops it
        out_ready = 1'b0;
        repeat (4) beat(1, 16'hFFFF);
        clr = 1'b1;
        beat(0, 0);
        clr = 1'b0;
        n_cmp++;
        if (ov0 !== 1'b0 || of1 !== 1'b0) begin
            n_err++;
            $display("FAIL clr_hold out_valid=%b ovf=%b want 0/0", ov0, of1);
        end
        out_ready = 1'b1;
        beat(0, 0);
    endtask

    task automatic test_reset_hold;
        out_ready = 1'b0;
        beat(1, 3); beat(1, 3); beat(1, 3); beat(1, 3);
        in_valid = 1'b0;
        n_cmp++;
        if (ov0 !== 1'b1 || acc0 !== 24'd12) begin
            n_err++;
            $display("FAIL rst_pre out_valid=%b acc_out=%0d want 1/12", ov0, acc0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ov0 !== 1'b0 || acc0 !== 24'd0) begin
            n_err++;
            $display("FAIL rst_async out_valid=%b acc_out=%0d want 0/0", ov0, acc0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ir0 !== 1'b1 || acc0 !== 24'd0 || of0 !== 1'b0 || ov0 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after in_ready=%b acc_out=%0d ovf=%b out_valid=%b want 1/0/0/0",
                     ir0, acc0, of0, ov0);
        end
        out_ready = 1'b1;
        beat(1, 1); beat(1, 2); beat(1, 3); beat(1, 4);
        n_cmp++;
        if (ov0 !== 1'b1 || acc0 !== 24'd10) begin
            n_err++;
            $display("FAIL rst_resume out_valid=%b acc_out=%0d want 1/10", ov0, acc0);
        end
        beat(0, 0);
        beat(0, 0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; prod = '0; out_ready = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_ovf;
        test_gaps;
        test_clr;
        test_reset_hold;
        n_cmp++;
        if (q0.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain %0d results never produced", q0.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/hslp_acc_stage.md
Name: hslp_acc_stage

Overview:
- Downstream consumer of the HSLP 8x8 approximate multiplier.
- Takes a stream of 16-bit approximate products and accumulates VEC_LEN of them into one dot-product sum.
- Returns the sum and an overflow flag over a valid/ready handshake.
- Turns the combinational multiplier into a usable MAC datapath for the FPGA error/energy evaluation builds.

Parameters:
- PROD_W, 16, width of incoming product (matches multiplier output).
- ACC_W, 24, accumulator/result width; must be >= PROD_W.
- VEC_LEN, 8, products per dot-product; must be >= 1.
- SAT, 1, 1 = saturate accumulator at all-ones on carry-out; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear, abandons the current vector.
- in_valid  input  1  prod is valid.
- in_ready  output  1  stage can accept a product.
- prod  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  acc_out/ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  ACC_W  completed dot-product sum.
- ovf  output  1  carry-out occurred at least once during this vector.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, count=0, acc_out=0, ovf=0, out_valid=0. in_ready is 1 once rst_n is high.
- Accept: a product is accepted when in_valid && in_ready.
- in_ready is 1 in IDLE and ACC, 0 in HOLD. It is combinational from state only, never from in_valid.
- count width is clog2(VEC_LEN+1). It counts accepted products only; cycles with in_valid low do not advance it.
- Arithmetic:
  - sum = acc + zero-extended prod, computed at ACC_W+1 bits.
  - A carry into bit ACC_W sets the sticky ovf_acc.
  - SAT=1: on carry, acc = all-ones; once saturated it stays saturated.
  - SAT=0: acc = sum[ACC_W-1:0].
- States:
  - IDLE: acc=0, count=0. Accept -> ACC, or -> HOLD directly if VEC_LEN=1.
  - ACC: each accept updates acc and count. The accept that makes count==VEC_LEN moves to HOLD.
  - HOLD: out_valid=1; acc_out and ovf registered with the final sum/flag. When out_valid && out_ready: -> IDLE, acc/count/ovf_acc cleared, out_valid=0 the next cycle.
- Latency and throughput:
  - out_valid rises the cycle after the last product is accepted (1-cycle latency).
  - Minimum VEC_LEN+1 cycles per vector, since there is no accept during HOLD.
- Stability: while out_valid && !out_ready, acc_out and ovf are held stable. in_valid activity during HOLD is ignored, not buffered.
- ovf output reflects ovf_acc of the completed vector. It is meaningful only while out_valid=1 and reads 0 otherwise.
- clr has highest priority among synchronous events:
  - Next state is IDLE; acc, count, ovf_acc, out_valid and ovf are cleared.
  - A product presented in the clr cycle is discarded even though in_ready=1.
  - A result pending in HOLD is dropped.
- Reset mid-operation: out_valid and in_ready-derived state clear immediately (async); no partial result is ever emitted.

Test Plan:
- VEC_LEN=4, SAT=1, prod 100,200,300,400 back-to-back with out_ready=1 -> out_valid one cycle after 4th accept; acc_out=1000, ovf=0; IDLE the following cycle.
- Same vector, out_ready=0 for 5 cycles with in_valid held 1 -> in_ready=0 and acc_out=1000 stable throughout, no extra products counted; out_ready=1 -> next vector starts from acc=0.
- ACC_W=17, VEC_LEN=4, four prod=0xFFFF:
  - SAT=1 -> acc_out=0x1FFFF, ovf=1.
  - SAT=0 -> acc_out=0x1FFFC, ovf=1.
- in_valid toggling 1,0,0,1,0,1,1 with prod=10 each accept (VEC_LEN=4) -> out_valid only after 4th accepted beat; acc_out=40.
- clr asserted after 2 products (5,7) in the same cycle as a third (9), then 1,2,3,4 -> acc_out=10, ovf=0.
- rst_n pulsed low while in HOLD -> out_valid drops without waiting for a clk edge; after release in_ready=1, acc_out=0.
